gpio_in_cond: RTL and testbench
===============================

GPIO_IN_COND -- requirements
Module: gpio_in_cond

Interface
REQ-001 SHALL have parameter WIDTH, default 64, number of GPIO input bits.
REQ-002 SHALL have parameter DEB_DIV, default 1000, clock cycles per debounce sample tick (legal range 2..65535).
REQ-003 SHALL have parameter DEB_SAMPLES, default 4, consecutive equal samples needed to accept a level (legal range 2..8).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_gpio  input  WIDTH  raw, asynchronous pad inputs.
REQ-007 i_rise_en  input  WIDTH  per-bit enable for rising-edge interrupt.
REQ-008 i_fall_en  input  WIDTH  per-bit enable for falling-edge interrupt.
REQ-009 i_clr  input  WIDTH  per-bit write-1-to-clear pulse for pending bits.
REQ-010 o_gpio  output  WIDTH  conditioned level; drives the i_gpio input of the SoC controller.
REQ-011 o_rise  output  WIDTH  one-cycle pulse per bit on a 0->1 change of o_gpio.
REQ-012 o_fall  output  WIDTH  one-cycle pulse per bit on a 1->0 change of o_gpio.
REQ-013 o_irq_pend  output  WIDTH  sticky per-bit edge-pending flags.
REQ-014 o_irq  output  1  level interrupt, OR of all o_irq_pend bits.

Function
REQ-015 Each i_gpio bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-016 o_gpio SHALL be a register; without debounce, o_gpio SHALL take sync2 every cycle, so an input change reaches o_gpio on the 3rd rising clk edge after it is stable at the pad.
REQ-017 The module SHALL hold a registered copy gpio_q of o_gpio, updated every cycle.
REQ-018 o_rise SHALL equal o_gpio AND NOT gpio_q, and o_fall SHALL equal gpio_q AND NOT o_gpio; each is high for exactly one cycle, the first cycle o_gpio shows the new level.
REQ-019 A pending bit SHALL set at the clk edge following (o_rise AND i_rise_en) OR (o_fall AND i_fall_en) for that bit.
REQ-020 A pending bit SHALL clear at the clk edge where i_clr is 1 for that bit.
REQ-021 When set and clear coincide on the same bit, set SHALL win (bit stays 1).
REQ-022 Pending bits SHALL not be affected by later changes of i_rise_en or i_fall_en.
REQ-023 o_irq SHALL be combinational from o_irq_pend, with no added delay.
REQ-024 Bits SHALL be fully independent; simultaneous edges on several bits SHALL each set their own pending bit.

Reset
REQ-025 While rst_n is 0, all registers SHALL clear to 0 immediately, without waiting for clk: sync1, sync2, o_gpio, gpio_q, o_irq_pend, prescaler and sample history.
REQ-026 Consequently o_rise, o_fall and o_irq SHALL be 0 during reset.
REQ-027 An input held high through reset release SHALL produce one o_rise pulse once it propagates; this is intended behaviour.
REQ-028 A reset asserted mid-debounce SHALL discard partial history; counting SHALL restart from 0 after release.

Configuration
REQ-029 Macro GPIO_IN_COND_DEBOUNCE_EN SHALL select the debounce feature.
REQ-030 When GPIO_IN_COND_DEBOUNCE_EN is defined, the following SHALL apply:
- A shared prescaler counts 0..DEB_DIV-1 and wraps to 0.
- A tick is the cycle where the count equals DEB_DIV-1.
- On each tick, each bit shifts sync2 into a DEB_SAMPLES-deep history.
- At the next edge, if all history bits are 1, o_gpio becomes 1; if all are 0, o_gpio becomes 0; otherwise o_gpio holds.
REQ-031 When GPIO_IN_COND_DEBOUNCE_EN is undefined, there SHALL be no prescaler or history logic, REQ-016 timing SHALL apply, and DEB_DIV and DEB_SAMPLES SHALL be ignored.

Verification
REQ-032 Debounce off: i_gpio[0] 0->1 at cycle 10 -> o_gpio[0]=1 from cycle 13; o_rise[0]=1 only in cycle 13; with i_rise_en[0]=1, o_irq_pend[0] and o_irq are 1 from cycle 14.
REQ-033 Pending and clear: pending[5]=1, then i_clr[5]=1 for one cycle -> pending[5]=0 and o_irq=0 next cycle; i_clr[5]=1 in the same cycle as o_fall[5] with i_fall_en[5]=1 -> pending[5] stays 1.
REQ-034 Masking: i_rise_en=0 and i_fall_en=0, toggle all 64 bits -> o_rise and o_fall pulse on all bits, o_irq_pend stays 0.
REQ-035 Debounce on (DEB_DIV=4, DEB_SAMPLES=3): a 2-cycle high glitch -> o_gpio and o_rise unchanged; input held high for 20 cycles -> o_gpio=1 within 2 + 3*4 + 1 = 15 cycles.
REQ-036 Async reset: drop rst_n mid-cycle with o_gpio=64'hFFFF and pending nonzero -> all outputs 0 before the next clk edge; after release with i_gpio held at 64'hFFFF -> one rise pulse on bits 15:0.

Source files
------------

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: two-flop synchronizer, edge detect and sticky edge-pending interrupt flags.
// Optional per-bit debounce filter is built when GPIO_IN_COND_DEBOUNCE_EN is defined.
module gpio_in_cond #(
    parameter int WIDTH       = 64,
    parameter int DEB_DIV     = 1000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_gpio,
    input  logic [WIDTH-1:0] i_rise_en,
    input  logic [WIDTH-1:0] i_fall_en,
    input  logic [WIDTH-1:0] i_clr,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_irq_pend,
    output logic             o_irq
);

    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] gpio_q_r;
    logic [WIDTH-1:0] pend_r;
    logic [WIDTH-1:0] set_s;

    // Reject debounce settings outside the supported range at elaboration
    if ((DEB_DIV < 2) || (DEB_DIV > 65535) || (DEB_SAMPLES < 2) || (DEB_SAMPLES > 8)) begin : g_bad_cfg
        $error("gpio_in_cond: DEB_DIV or DEB_SAMPLES out of range");
    end

    // Two-flop synchronizer for the asynchronous pad inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= {WIDTH{1'b0}};
            sync2_r <= {WIDTH{1'b0}};
        end else begin
            sync1_r <= i_gpio;
            sync2_r <= sync1_r;
        end
    end

`ifdef GPIO_IN_COND_DEBOUNCE_EN
    logic [15:0]            cnt_r;
    logic                   tick_s;
    logic [DEB_SAMPLES-1:0] hist_r [WIDTH];

    assign tick_s = (cnt_r == 16'(DEB_DIV - 1));

    // Shared sample-tick prescaler
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 16'd0;
        end else if (tick_s) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Per-bit sample history; level accepted only when every sample agrees
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_r[i] <= {DEB_SAMPLES{1'b0}};
            end
            o_gpio <= {WIDTH{1'b0}};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (tick_s) begin
                    hist_r[i] <= {hist_r[i][DEB_SAMPLES-2:0], sync2_r[i]};
                end else begin
                    hist_r[i] <= hist_r[i];
                end
                if (&hist_r[i]) begin
                    o_gpio[i] <= 1'b1;
                end else if (~|hist_r[i]) begin
                    o_gpio[i] <= 1'b0;
                end else begin
                    o_gpio[i] <= o_gpio[i];
                end
            end
        end
    end
`else
    // Without the filter the conditioned level simply follows the synchronizer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_gpio <= {WIDTH{1'b0}};
        end else begin
            o_gpio <= sync2_r;
        end
    end
`endif

    assign o_rise = o_gpio & ~gpio_q_r;
    assign o_fall = gpio_q_r & ~o_gpio;
    assign set_s  = (o_rise & i_rise_en) | (o_fall & i_fall_en);

    // Delayed level for edge detection and sticky pending flags (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_q_r <= {WIDTH{1'b0}};
            pend_r   <= {WIDTH{1'b0}};
        end else begin
            gpio_q_r <= o_gpio;
            pend_r   <= (pend_r & ~i_clr) | set_s;
        end
    end

    assign o_irq_pend = pend_r;
    assign o_irq      = |pend_r;

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed self-checking bench for gpio_in_cond; follows the debounce build when
// GPIO_IN_COND_DEBOUNCE_EN is defined (DEB_DIV=4, DEB_SAMPLES=3).
module tb_gpio_in_cond;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] gpio;
    logic [63:0] rise_en;
    logic [63:0] fall_en;
    logic [63:0] clr;
    logic [63:0] o_gpio;
    logic [63:0] o_rise;
    logic [63:0] o_fall;
    logic [63:0] o_irq_pend;
    logic        o_irq;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] ZERO = 64'h0;
    localparam logic [63:0] ONES = {64{1'b1}};

    gpio_in_cond #(.WIDTH(64), .DEB_DIV(4), .DEB_SAMPLES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_gpio     (gpio),
        .i_rise_en  (rise_en),
        .i_fall_en  (fall_en),
        .i_clr      (clr),
        .o_gpio     (o_gpio),
        .o_rise     (o_rise),
        .o_fall     (o_fall),
        .o_irq_pend (o_irq_pend),
        .o_irq      (o_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gpio"}, o_gpio, ZERO);
        chk({tag, "_rise"}, o_rise, ZERO);
        chk({tag, "_fall"}, o_fall, ZERO);
        chk({tag, "_pend"}, o_irq_pend, ZERO);
        chk({tag, "_irq"}, {63'd0, o_irq}, ZERO);
    endtask

    initial begin
        int  n;
        logic seen;
        rst_n   = 1'b0;
        gpio    = ZERO;
        rise_en = ZERO;
        fall_en = ZERO;
        clr     = ZERO;
        step(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        step(1);

`ifndef GPIO_IN_COND_DEBOUNCE_EN
        // Bit 0 rise: level on the 3rd edge, pending one edge later
        rise_en = 64'h1;
        gpio    = 64'h1;
        step(2);
        chk("rise_lat_early", o_gpio, ZERO);
        step(1);
        chk("rise_lat_gpio", o_gpio, 64'h1);
        chk("rise_pulse", o_rise, 64'h1);
        chk("rise_pend_early", o_irq_pend, ZERO);
        step(1);
        chk("rise_pulse_end", o_rise, ZERO);
        chk("rise_pend", o_irq_pend, 64'h1);
        chk("rise_irq", {63'd0, o_irq}, 64'h1);
        clr = 64'h1;
        step(1);
        clr = ZERO;
        chk("clr0_pend", o_irq_pend, ZERO);
        chk("clr0_irq", {63'd0, o_irq}, ZERO);

        // Bit 5 pending, clear, then clear colliding with a new fall
        rise_en = 64'h20;
        fall_en = 64'h20;
        gpio    = 64'h21;
        step(4);
        chk("b5_pend", o_irq_pend, 64'h20);
        clr = 64'h20;
        step(1);
        clr = ZERO;
        chk("b5_clr_pend", o_irq_pend, ZERO);
        chk("b5_clr_irq", {63'd0, o_irq}, ZERO);
        gpio = 64'h1;
        step(3);
        chk("b5_fall", o_fall, 64'h20);
        clr = 64'h20;
        step(1);
        clr = ZERO;
        chk("set_wins", o_irq_pend, 64'h20);
        rise_en = ZERO;
        fall_en = ZERO;
        step(2);
        chk("en_change_sticky", o_irq_pend, 64'h20);
        clr = ONES;
        step(1);
        clr = ZERO;
        chk("clr_all", o_irq_pend, ZERO);

        // Masked: all bits toggle, no pending
        gpio = ZERO;
        step(4);
        gpio = ONES;
        step(3);
        chk("mask_rise", o_rise, ONES);
        chk("mask_rise_pend", o_irq_pend, ZERO);
        step(1);
        chk("mask_rise_end", o_rise, ZERO);
        gpio = ZERO;
        step(3);
        chk("mask_fall", o_fall, ONES);
        step(1);
        chk("mask_fall_pend", o_irq_pend, ZERO);
        chk("mask_irq", {63'd0, o_irq}, ZERO);

        // Simultaneous edges on independent bits
        rise_en = ONES;
        gpio    = 64'h8000_0000_0000_0081;
        step(4);
        chk("multi_pend", o_irq_pend, 64'h8000_0000_0000_0081);
        clr = 64'h1;
        step(1);
        clr = ZERO;
        chk("multi_clr", o_irq_pend, 64'h8000_0000_0000_0080);

        // Asynchronous reset mid-cycle, then release with inputs held high
        gpio = 64'hFFFF;
        step(4);
        chk("pre_rst_gpio", o_gpio, 64'hFFFF);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step(2);
        #3;
        rst_n = 1'b1;
        step(2);
        chk("post_rst_rise_early", o_rise, ZERO);
        step(1);
        chk("post_rst_rise", o_rise, 64'hFFFF);
        step(1);
        chk("post_rst_rise_end", o_rise, ZERO);
        chk("post_rst_pend", o_irq_pend, 64'hFFFF);
`else
        // Two-cycle glitch must not pass the filter
        rise_en = 64'h1;
        gpio    = 64'h1;
        step(2);
        gpio = ZERO;
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(1);
            if (o_gpio[0] || o_rise[0]) seen = 1'b1;
        end
        chk("glitch_blocked", {63'd0, seen}, ZERO);
        chk("glitch_pend", o_irq_pend, ZERO);

        // Held level accepted within 2 + 3*4 + 1 cycles
        gpio = 64'h1;
        n    = 0;
        while (o_gpio[0] !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        chk("deb_latency_ok", {63'd0, (n <= 15)}, 64'h1);
        chk("deb_rise", o_rise, 64'h1);
        step(1);
        chk("deb_pend", o_irq_pend, 64'h1);

        // Reset mid-debounce clears everything immediately
        gpio = ZERO;
        step(5);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("deb_async_rst");
        step(2);
        rst_n = 1'b1;
        step(20);
        chk("deb_post_rst_gpio", o_gpio, ZERO);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
